pe_feeder: RTL and testbench

Sequencer that drives the parallel PE for one matrix-vector pass. It streams 512-bit neuron and weight words out of the neuron and weight SRAMs into the PE, generating `vld` and the 2-bit `ctl` (bit0 = clear partial sum, bit1 = last block). It captures each completed 32-bit PE result into the result buffer. It sits between the on-chip buffers and the PE, and is started by the top-level controller.

---
 rtl/pe_pkg.sv | 18 +
 rtl/pe_loop_cnt.sv | 63 ++++++
 rtl/pe_feeder.sv | 126 ++++++++++++
 tb/tb_pe_feeder.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared types and constants for the PE feeder: FSM state encoding, datapath widths
// and the bit positions inside the 2-bit PE control word.
package pe_pkg;

  localparam int unsigned PE_DATA_W = 512;
  localparam int unsigned PE_RES_W  = 32;

  localparam int unsigned CTL_CLR  = 0;
  localparam int unsigned CTL_LAST = 1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } pe_state_e;

endpackage

// File: rtl/pe_loop_cnt.sv
// Nested read-loop counters for one pass: block index inside an output, output index,
// and a running weight address that advances once per issued read.
module pe_loop_cnt #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned WADDR_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr_i,
  input  logic               adv_i,
  input  logic [CNT_W-1:0]   in_blocks_i,
  input  logic [CNT_W-1:0]   out_num_i,
  output logic [CNT_W-1:0]   blk_o,
  output logic [WADDR_W-1:0] waddr_o,
  output logic               blk_first_o,
  output logic               blk_last_o,
  output logic               pass_last_o
);

  logic [CNT_W-1:0]   blk_q, blk_d;
  logic [CNT_W-1:0]   outc_q, outc_d;
  logic [WADDR_W-1:0] waddr_q, waddr_d;
  logic               outc_last;

  assign blk_first_o = (blk_q == '0);
  assign blk_last_o  = (blk_q == in_blocks_i - 1'b1);
  assign outc_last   = (outc_q == out_num_i - 1'b1);
  assign pass_last_o = blk_last_o & outc_last;
  assign blk_o       = blk_q;
  assign waddr_o     = waddr_q;

  always_comb begin
    blk_d   = blk_q;
    outc_d  = outc_q;
    waddr_d = waddr_q;
    if (clr_i) begin
      blk_d   = '0;
      outc_d  = '0;
      waddr_d = '0;
    end else if (adv_i) begin
      waddr_d = waddr_q + 1'b1;
      if (blk_last_o) begin
        blk_d  = '0;
        outc_d = outc_last ? '0 : outc_q + 1'b1;
      end else begin
        blk_d = blk_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_q   <= '0;
      outc_q  <= '0;
      waddr_q <= '0;
    end else begin
      blk_q   <= blk_d;
      outc_q  <= outc_d;
      waddr_q <= waddr_d;
    end
  end

endmodule

// File: rtl/pe_feeder.sv
// Sequences one matrix-vector pass: streams neuron/weight SRAM words into the PE with
// clear/last control and writes each finished PE sum into the result buffer.
module pe_feeder
  import pe_pkg::*;
#(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned WADDR_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [CNT_W-1:0]     in_blocks_i,
  input  logic [CNT_W-1:0]     out_num_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 nrn_rd_en_o,
  output logic [CNT_W-1:0]     nrn_addr_o,
  input  logic [PE_DATA_W-1:0] nrn_rdata_i,
  output logic                 wgt_rd_en_o,
  output logic [WADDR_W-1:0]   wgt_addr_o,
  input  logic [PE_DATA_W-1:0] wgt_rdata_i,
  output logic [PE_DATA_W-1:0] pe_neuron_o,
  output logic [PE_DATA_W-1:0] pe_weight_o,
  output logic [1:0]           pe_ctl_o,
  output logic                 pe_vld_o,
  input  logic [PE_RES_W-1:0]  pe_result_i,
  input  logic                 pe_vld_o_i,
  output logic                 res_wr_en_o,
  output logic [CNT_W-1:0]     res_addr_o,
  output logic [PE_RES_W-1:0]  res_wdata_o
);

  pe_state_e        state_q;
  logic [CNT_W-1:0] inb_q, outn_q, wr_q;
  logic             pe_vld_q;
  logic [1:0]       pe_ctl_q, pe_ctl_d;

  logic               rd_en, cnt_clr;
  logic               blk_first, blk_last, pass_last;
  logic [CNT_W-1:0]   blk;
  logic [WADDR_W-1:0] waddr;

  assign rd_en   = (state_q == StRun);
  assign cnt_clr = (state_q == StIdle) & start_i;

  pe_loop_cnt #(
    .CNT_W   (CNT_W),
    .WADDR_W (WADDR_W)
  ) u_loop_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (cnt_clr),
    .adv_i       (rd_en),
    .in_blocks_i (inb_q),
    .out_num_i   (outn_q),
    .blk_o       (blk),
    .waddr_o     (waddr),
    .blk_first_o (blk_first),
    .blk_last_o  (blk_last),
    .pass_last_o (pass_last)
  );

  // Control travels with the read so it lines up with the data returning next cycle.
  always_comb begin
    pe_ctl_d = '0;
    if (rd_en) begin
      pe_ctl_d[CTL_CLR]  = blk_first;
      pe_ctl_d[CTL_LAST] = blk_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      inb_q    <= '0;
      outn_q   <= '0;
      wr_q     <= '0;
      pe_vld_q <= 1'b0;
      pe_ctl_q <= '0;
    end else begin
      pe_vld_q <= rd_en;
      pe_ctl_q <= pe_ctl_d;
      if (pe_vld_o_i) begin
        wr_q <= wr_q + 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            inb_q   <= in_blocks_i;
            outn_q  <= out_num_i;
            wr_q    <= '0;
            state_q <= (in_blocks_i == '0 || out_num_i == '0) ? StDone : StRun;
          end
        end
        StRun: begin
          if (pass_last) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (pe_vld_o_i && wr_q == outn_q - 1'b1) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy_o      = (state_q != StIdle);
  assign done_o      = (state_q == StDone);
  assign nrn_rd_en_o = rd_en;
  assign wgt_rd_en_o = rd_en;
  assign nrn_addr_o  = blk;
  assign wgt_addr_o  = waddr;
  assign pe_neuron_o = nrn_rdata_i;
  assign pe_weight_o = wgt_rdata_i;
  assign pe_vld_o    = pe_vld_q;
  assign pe_ctl_o    = pe_ctl_q;
  assign res_wr_en_o = pe_vld_o_i;
  assign res_addr_o  = wr_q;
  assign res_wdata_o = pe_result_i;

endmodule

// File: tb/tb_pe_feeder.sv
// Bench for pe_feeder: SRAM and int16-lane PE models around the DUT, with every pass
// compared against cycle/address/result expectations derived from the pass geometry.
module tb_pe_feeder;

  localparam int unsigned CntW   = 8;
  localparam int unsigned WaddrW = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [CntW-1:0]   in_blocks = '0;
  logic [CntW-1:0]   out_num = '0;
  logic              busy, done;
  logic              nrn_rd_en, wgt_rd_en;
  logic [CntW-1:0]   nrn_addr;
  logic [WaddrW-1:0] wgt_addr;
  logic [511:0]      nrn_rdata = '0;
  logic [511:0]      wgt_rdata = '0;
  logic [511:0]      pe_neuron, pe_weight;
  logic [1:0]        pe_ctl;
  logic              pe_vld;
  logic [31:0]       pe_result;
  logic              pe_res_vld;
  logic              res_wr_en;
  logic [CntW-1:0]   res_addr;
  logic [31:0]       res_wdata;

  always #5 clk = ~clk;

  pe_feeder #(
    .CNT_W   (CntW),
    .WADDR_W (WaddrW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start),
    .in_blocks_i (in_blocks),
    .out_num_i   (out_num),
    .busy_o      (busy),
    .done_o      (done),
    .nrn_rd_en_o (nrn_rd_en),
    .nrn_addr_o  (nrn_addr),
    .nrn_rdata_i (nrn_rdata),
    .wgt_rd_en_o (wgt_rd_en),
    .wgt_addr_o  (wgt_addr),
    .wgt_rdata_i (wgt_rdata),
    .pe_neuron_o (pe_neuron),
    .pe_weight_o (pe_weight),
    .pe_ctl_o    (pe_ctl),
    .pe_vld_o    (pe_vld),
    .pe_result_i (pe_result),
    .pe_vld_o_i  (pe_res_vld),
    .res_wr_en_o (res_wr_en),
    .res_addr_o  (res_addr),
    .res_wdata_o (res_wdata)
  );

  logic [511:0] nrn_mem [256];
  logic [511:0] wgt_mem [1024];

  function automatic int dot(input logic [511:0] a, input logic [511:0] b);
    int s;
    s = 0;
    for (int l = 0; l < 32; l++) begin
      s += int'($signed(a[l*16 +: 16])) * int'($signed(b[l*16 +: 16]));
    end
    return s;
  endfunction

  // SRAMs: registered read, data one cycle after the enable
  always @(posedge clk) begin
    if (nrn_rd_en) nrn_rdata <= nrn_mem[nrn_addr];
    if (wgt_rd_en) wgt_rdata <= wgt_mem[wgt_addr[9:0]];
  end

  // PE: accumulate per beat, restart on clear, present the sum a cycle after the last beat
  int acc_q;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= 0;
      pe_result  <= '0;
      pe_res_vld <= 1'b0;
    end else begin
      pe_res_vld <= 1'b0;
      if (pe_vld) begin
        acc_q <= (pe_ctl[0] ? 0 : acc_q) + dot(pe_neuron, pe_weight);
        if (pe_ctl[1]) begin
          pe_result  <= (pe_ctl[0] ? 0 : acc_q) + dot(pe_neuron, pe_weight);
          pe_res_vld <= 1'b1;
        end
      end
    end
  end

  // Event log per pass, indexed by cycle relative to the first RUN cycle
  typedef struct packed {int c; int x; int y; int z;} ev_t;
  ev_t rd_q[$];
  ev_t vld_q[$];
  ev_t wr_q[$];
  int  done_q[$];
  int  busy_q[$];
  int  cyc = 0;
  int  base = 1 << 30;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cyc >= base) begin
      if (nrn_rd_en || wgt_rd_en)
        rd_q.push_back('{cyc - base, int'(nrn_addr), int'(wgt_addr),
                         int'({nrn_rd_en, wgt_rd_en})});
      if (pe_vld) vld_q.push_back('{cyc - base, int'(pe_ctl), 0, 0});
      if (res_wr_en) wr_q.push_back('{cyc - base, int'(res_addr), int'(res_wdata), 0});
      if (done) done_q.push_back(cyc - base);
      if (busy) busy_q.push_back(cyc - base);
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_result(input int k, input int b);
    int s;
    s = 0;
    for (int i = 0; i < b; i++) s += dot(nrn_mem[i], wgt_mem[(k * b + i) % 1024]);
    return s;
  endfunction

  task automatic fill_const();
    logic [511:0] nv, wv;
    for (int l = 0; l < 32; l++) begin
      nv[l*16 +: 16] = 16'd1;
      wv[l*16 +: 16] = 16'd2;
    end
    for (int i = 0; i < 256; i++) nrn_mem[i] = nv;
    for (int i = 0; i < 1024; i++) wgt_mem[i] = wv;
  endtask

  task automatic fill_rand();
    logic [511:0] v;
    for (int i = 0; i < 256; i++) begin
      for (int j = 0; j < 16; j++) v[j*32 +: 32] = $urandom;
      nrn_mem[i] = v;
    end
    for (int i = 0; i < 1024; i++) begin
      for (int j = 0; j < 16; j++) v[j*32 +: 32] = $urandom;
      wgt_mem[i] = v;
    end
  endtask

  // One full pass; glitch >= 0 pulses a bogus start in that RUN cycle
  task automatic run_pass(input int b, input int o, input int glitch);
    int n, dexp, bi;
    bit seen;
    n    = b * o;
    dexp = (n == 0) ? 0 : n + 2;
    @(negedge clk);
    base = cyc + 1;
    rd_q.delete();
    vld_q.delete();
    wr_q.delete();
    done_q.delete();
    busy_q.delete();
    start     = 1'b1;
    in_blocks = CntW'(b);
    out_num   = CntW'(o);
    @(negedge clk);
    start     = 1'b0;
    in_blocks = CntW'($urandom_range(1, 255));
    out_num   = CntW'($urandom_range(1, 255));
    seen      = 1'b0;
    for (int t = 0; t < n + 20 && !seen; t++) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        start = (t == glitch);
        @(negedge clk);
      end
    end
    start = 1'b0;
    #1;
    check("done_seen", seen, 1);
    check("done_cnt", done_q.size(), 1);
    if (done_q.size() > 0) check("done_cycle", done_q[0], dexp);
    check("busy_len", busy_q.size(), dexp + 1);
    if (busy_q.size() > 0) check("busy_first", busy_q[0], 0);
    check("rd_cnt", rd_q.size(), n);
    for (int i = 0; i < rd_q.size() && i < n; i++) begin
      check("rd_cycle", rd_q[i].c, i);
      check("rd_en_pair", rd_q[i].z, 3);
      check("nrn_addr", rd_q[i].x, i % b);
      check("wgt_addr", rd_q[i].y, i);
    end
    check("vld_cnt", vld_q.size(), n);
    for (int i = 0; i < vld_q.size() && i < n; i++) begin
      bi = i % b;
      check("vld_cycle", vld_q[i].c, i + 1);
      check("pe_ctl", vld_q[i].x, ((bi == b - 1) ? 2 : 0) + ((bi == 0) ? 1 : 0));
    end
    check("wr_cnt", wr_q.size(), o * ((b == 0) ? 0 : 1));
    for (int k = 0; k < wr_q.size() && b > 0 && k < o; k++) begin
      check("wr_cycle", wr_q[k].c, (k + 1) * b + 1);
      check("res_addr", wr_q[k].x, k);
      check("res_wdata", wr_q[k].y, ref_result(k, b));
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_nrn_rd", nrn_rd_en, 0);
    check("rst_wgt_rd", wgt_rd_en, 0);
    check("rst_pe_vld", pe_vld, 0);
    check("rst_pe_ctl", pe_ctl, 0);
    check("rst_wr_en", res_wr_en, 0);
    check("rst_addrs", {nrn_addr, wgt_addr, res_addr}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    fill_const();
    run_pass(1, 1, -1);
    run_pass(4, 2, -1);
    run_pass(0, 5, -1);
    run_pass(3, 0, -1);
    run_pass(4, 2, 2);

    // Reset in the middle of a pass
    @(negedge clk);
    start     = 1'b1;
    in_blocks = 8'd4;
    out_num   = 8'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_rd", {nrn_rd_en, wgt_rd_en}, 0);
    check("mrst_vld", pe_vld, 0);
    check("mrst_ctl", pe_ctl, 0);
    check("mrst_wr", res_wr_en, 0);
    check("mrst_addrs", {nrn_addr, wgt_addr, res_addr}, 0);
    repeat (2) begin
      @(negedge clk);
      check("mrst_hold", {done, busy, nrn_rd_en, res_wr_en}, 0);
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_idle", {done, busy, nrn_rd_en, res_wr_en}, 0);
    end
    run_pass(4, 2, -1);

    // Back-to-back passes
    run_pass(2, 3, -1);
    run_pass(2, 3, -1);

    fill_rand();
    repeat (4) begin
      int b, o;
      b = $urandom_range(1, 6);
      o = $urandom_range(1, 6);
      run_pass(b, o, $urandom_range(0, b * o - 1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
